// File: rtl/frv_masked_barith_arbiter.sv
// rtl/frv_masked_barith_arbiter.sv - round-robin arbiter sharing a 2-share masked add/sub unit between two requesters
// Optional PRE idle cycle after each response when FRV_MASKED_ARB_PRECHARGE_EN is defined.
module frv_masked_barith_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int TMO_CYC   = 64
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 flush,
    input  logic                 req0_valid,
    input  logic                 req0_sub,
    input  logic [BIT_WIDTH-1:0] req0_rs1_s0,
    input  logic [BIT_WIDTH-1:0] req0_rs1_s1,
    input  logic [BIT_WIDTH-1:0] req0_rs2_s0,
    input  logic [BIT_WIDTH-1:0] req0_rs2_s1,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic                 req1_sub,
    input  logic [BIT_WIDTH-1:0] req1_rs1_s0,
    input  logic [BIT_WIDTH-1:0] req1_rs1_s1,
    input  logic [BIT_WIDTH-1:0] req1_rs2_s0,
    input  logic [BIT_WIDTH-1:0] req1_rs2_s1,
    output logic                 req1_ready,
    output logic                 rsp0_done,
    output logic                 rsp1_done,
    output logic [BIT_WIDTH-1:0] rsp_s0,
    output logic [BIT_WIDTH-1:0] rsp_s1,
    output logic                 err_tmo,
    output logic                 u_valid,
    output logic                 u_op_add,
    output logic                 u_op_sub,
    output logic                 u_flush,
    output logic [BIT_WIDTH-1:0] u_rs1_s0,
    output logic [BIT_WIDTH-1:0] u_rs1_s1,
    output logic [BIT_WIDTH-1:0] u_rs2_s0,
    output logic [BIT_WIDTH-1:0] u_rs2_s1,
    input  logic                 u_ready,
    input  logic [BIT_WIDTH-1:0] u_rd_s0,
    input  logic [BIT_WIDTH-1:0] u_rd_s1
);
    localparam int CW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_PRE} state_t;

    state_t               state, state_nxt;
    logic                 last_grant, owner, op_sub;
    logic [BIT_WIDTH-1:0] rs1_s0_q, rs1_s1_q, rs2_s0_q, rs2_s1_q;
    logic [BIT_WIDTH-1:0] rd_s0_q, rd_s1_q;
    logic [CW-1:0]        tmo_cnt;
    logic                 grant, grant_port, tmo_hit, capture, hold_ops, done_any;

    always_comb begin
        grant      = 1'b0;
        grant_port = 1'b0;
        if (state == S_IDLE && !flush) begin
            if (req0_valid && req1_valid) begin
                grant      = 1'b1;
                grant_port = ~last_grant;
            end else if (req0_valid || req1_valid) begin
                grant      = 1'b1;
                grant_port = req1_valid;
            end
        end
    end

    assign tmo_hit  = (state == S_ISSUE) && !u_ready && (tmo_cnt == CW'(TMO_CYC - 1));
    assign capture  = (state == S_ISSUE) && u_ready && !flush;
    assign hold_ops = (state == S_ISSUE) && (state_nxt == S_ISSUE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (flush || tmo_hit) state_nxt = S_IDLE;
                else if (u_ready)     state_nxt = S_RESP;
            end
`ifdef FRV_MASKED_ARB_PRECHARGE_EN
            S_RESP:  state_nxt = flush ? S_IDLE : S_PRE;
`else
            S_RESP:  state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_sub     <= 1'b0;
            tmo_cnt    <= '0;
            rs1_s0_q   <= '0;
            rs1_s1_q   <= '0;
            rs2_s0_q   <= '0;
            rs2_s1_q   <= '0;
            rd_s0_q    <= '0;
            rd_s1_q    <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= hold_ops ? tmo_cnt + 1'b1 : '0;
            // operand shares are only ever muxed per share, never combined
            if (grant) begin
                rs1_s0_q   <= grant_port ? req1_rs1_s0 : req0_rs1_s0;
                rs1_s1_q   <= grant_port ? req1_rs1_s1 : req0_rs1_s1;
                rs2_s0_q   <= grant_port ? req1_rs2_s0 : req0_rs2_s0;
                rs2_s1_q   <= grant_port ? req1_rs2_s1 : req0_rs2_s1;
                op_sub     <= grant_port ? req1_sub : req0_sub;
                owner      <= grant_port;
                last_grant <= grant_port;
            end else if (!hold_ops) begin
                rs1_s0_q <= '0;
                rs1_s1_q <= '0;
                rs2_s0_q <= '0;
                rs2_s1_q <= '0;
            end
            rd_s0_q <= capture ? u_rd_s0 : '0;
            rd_s1_q <= capture ? u_rd_s1 : '0;
        end
    end

    assign done_any = g_resetn && (state == S_RESP) && !flush;

    always_comb begin
        req0_ready = g_resetn && grant && !grant_port;
        req1_ready = g_resetn && grant && grant_port;
        rsp0_done  = done_any && !owner;
        rsp1_done  = done_any && owner;
        rsp_s0     = done_any ? rd_s0_q : '0;
        rsp_s1     = done_any ? rd_s1_q : '0;
        u_valid    = g_resetn && (state == S_ISSUE);
        u_op_add   = u_valid && !op_sub;
        u_op_sub   = u_valid && op_sub;
        u_flush    = g_resetn && (flush || tmo_hit);
        err_tmo    = g_resetn && tmo_hit && !flush;
    end

    assign u_rs1_s0 = rs1_s0_q;
    assign u_rs1_s1 = rs1_s1_q;
    assign u_rs2_s0 = rs2_s0_q;
    assign u_rs2_s1 = rs2_s1_q;

endmodule

// File: tb/tb_frv_masked_barith_arbiter.sv
// tb/tb_frv_masked_barith_arbiter.sv - self-checking bench for frv_masked_barith_arbiter
module tb_frv_masked_barith_arbiter;
    localparam int W   = 32;
    localparam int TMO = 8;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    logic flush = 1'b0;
    logic r_valid [2];
    logic r_sub [2];
    logic [W-1:0] r1s0 [2], r1s1 [2], r2s0 [2], r2s1 [2];
    logic u_ready = 1'b0;
    logic [W-1:0] u_rd_s0 = '0, u_rd_s1 = '0;

    logic req0_ready, req1_ready, rsp0_done, rsp1_done, err_tmo;
    logic u_valid, u_op_add, u_op_sub, u_flush;
    logic [W-1:0] rsp_s0, rsp_s1, u_rs1_s0, u_rs1_s1, u_rs2_s0, u_rs2_s1;

    int total = 0;
    int bad = 0;
    int last_g = 1;

    always #5 g_clk = ~g_clk;

    frv_masked_barith_arbiter #(.BIT_WIDTH(W), .TMO_CYC(TMO)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .req0_valid(r_valid[0]), .req0_sub(r_sub[0]),
        .req0_rs1_s0(r1s0[0]), .req0_rs1_s1(r1s1[0]), .req0_rs2_s0(r2s0[0]), .req0_rs2_s1(r2s1[0]),
        .req0_ready(req0_ready),
        .req1_valid(r_valid[1]), .req1_sub(r_sub[1]),
        .req1_rs1_s0(r1s0[1]), .req1_rs1_s1(r1s1[1]), .req1_rs2_s0(r2s0[1]), .req1_rs2_s1(r2s1[1]),
        .req1_ready(req1_ready),
        .rsp0_done(rsp0_done), .rsp1_done(rsp1_done), .rsp_s0(rsp_s0), .rsp_s1(rsp_s1),
        .err_tmo(err_tmo), .u_valid(u_valid), .u_op_add(u_op_add), .u_op_sub(u_op_sub),
        .u_flush(u_flush), .u_rs1_s0(u_rs1_s0), .u_rs1_s1(u_rs1_s1),
        .u_rs2_s0(u_rs2_s0), .u_rs2_s1(u_rs2_s1),
        .u_ready(u_ready), .u_rd_s0(u_rd_s0), .u_rd_s1(u_rd_s1)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic rnd(input int p);
        r_sub[p] = 1'($urandom % 2);
        r1s0[p] = $urandom; r1s1[p] = $urandom;
        r2s0[p] = $urandom; r2s1[p] = $urandom;
    endtask

    // round-robin reference: both pending -> the port not served last
    function automatic int pick();
        if (r_valid[0] && r_valid[1]) return 1 - last_g;
        return r_valid[0] ? 0 : 1;
    endfunction

    // dly = u_ready on that ISSUE cycle (0 = never); flush_at = ISSUE cycle carrying flush (0 = none)
    task automatic op(input int dly, input int flush_at, input bit keep, input bit rst_resp);
        int p, n;
        bit got, sb;
        logic [W-1:0] c10, c11, c20, c21, a, b, expv, mask;
        got = 1'b0;
        for (int w = 0; w < 6 && !got; w++) begin
            #1;
            if (req0_ready || req1_ready) got = 1'b1;
            else clk_step();
        end
        chk("grant_seen", W'(got), 1);
        if (!got) return;
        p = pick();
        chk("grant_port", {30'd0, req1_ready, req0_ready}, W'(1 << p));
        last_g = p;
        c10 = r1s0[p]; c11 = r1s1[p]; c20 = r2s0[p]; c21 = r2s1[p]; sb = r_sub[p];
        a = c10 ^ c11; b = c20 ^ c21;
        expv = sb ? a - b : a + b;
        clk_step();
        if (keep) rnd(p); else r_valid[p] = 1'b0;
        n = (dly == 0) ? TMO : dly;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) clk_step();
            mask = $urandom;
            u_ready = (i == dly);
            u_rd_s0 = mask; u_rd_s1 = expv ^ mask;
            flush = (i == flush_at);
            #1;
            chk("u_valid_issue", W'(u_valid), 1);
            chk("u_op_sub", W'(u_op_sub), W'(sb));
            chk("u_op_add", W'(u_op_add), W'(!sb));
            if (i == 1) begin
                chk("u_rs1_s0", u_rs1_s0, c10); chk("u_rs1_s1", u_rs1_s1, c11);
                chk("u_rs2_s0", u_rs2_s0, c20); chk("u_rs2_s1", u_rs2_s1, c21);
            end
            if (i == flush_at) begin
                chk("u_flush", W'(u_flush), 1);
                chk("err_tmo_flush", W'(err_tmo), 0);
                clk_step();
                flush = 1'b0; u_ready = 1'b0;
                #1;
                chk("done_after_flush", {30'd0, rsp1_done, rsp0_done}, 0);
                chk("u_rs_after_flush", u_rs1_s0 | u_rs1_s1 | u_rs2_s0 | u_rs2_s1, 0);
                chk("u_valid_after_flush", W'(u_valid), 0);
                return;
            end
            chk("err_tmo", W'(err_tmo), W'(dly == 0 && i == TMO));
            if (dly == 0) chk("u_flush_tmo", W'(u_flush), W'(i == TMO));
        end
        clk_step();
        u_ready = 1'b0; u_rd_s0 = $urandom; u_rd_s1 = $urandom;
        if (dly == 0) begin
            #1;
            chk("u_valid_after_tmo", W'(u_valid), 0);
            chk("err_tmo_after", W'(err_tmo), 0);
            chk("done_after_tmo", {30'd0, rsp1_done, rsp0_done}, 0);
            return;
        end
        if (rst_resp) begin
            g_resetn = 1'b0;
            #1;
            chk("done_in_reset", {30'd0, rsp1_done, rsp0_done}, 0);
            clk_step();
            g_resetn = 1'b1;
            r_valid[0] = 1'b0; r_valid[1] = 1'b0;
            last_g = 1;
            #1;
            chk("post_rst_outs", {24'd0, u_valid, u_flush, err_tmo, u_op_add, u_op_sub,
                                  rsp0_done, rsp1_done, req0_ready | req1_ready}, 0);
            chk("post_rst_shares", rsp_s0 | rsp_s1 | u_rs1_s0 | u_rs2_s1, 0);
            return;
        end
        #1;
        chk("done_port", {30'd0, rsp1_done, rsp0_done}, W'(1 << p));
        chk("rsp_value", rsp_s0 ^ rsp_s1, expv);
        chk("u_valid_resp", W'(u_valid), 0);
        chk("u_rs_resp", u_rs1_s0 | u_rs2_s0, 0);
        clk_step();
        #1;
        chk("rsp_cleared", rsp_s0 | rsp_s1, 0);
        chk("done_cleared", {30'd0, rsp1_done, rsp0_done}, 0);
    endtask

    initial begin
        r_valid[0] = 1'b0; r_valid[1] = 1'b0;
        rnd(0); rnd(1);
        clk_step(); clk_step();
        chk("rst_outs", {25'd0, u_valid, u_flush, err_tmo, rsp0_done, rsp1_done, req0_ready, req1_ready}, 0);
        chk("rst_shares", rsp_s0 | rsp_s1 | u_rs1_s0 | u_rs1_s1 | u_rs2_s0 | u_rs2_s1, 0);
        g_resetn = 1'b1;
        clk_step();

        r_sub[0] = 1'b0;
        r1s0[0] = 32'hA5A5A5A5; r1s1[0] = 32'hA5A5A5A0;
        r2s0[0] = 32'h0F0F0F0F; r2s1[0] = 32'h0F0F0F0C;
        r_valid[0] = 1'b1;
        op(6, 0, 0, 0);
        r_sub[0] = 1'b1; r_valid[0] = 1'b1;
        op(6, 0, 0, 0);

        g_resetn = 1'b0; last_g = 1;
        clk_step();
        g_resetn = 1'b1;
        rnd(0); rnd(1); r_valid[0] = 1'b1; r_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) op(int'($urandom_range(1, 6)), 0, 1, 0);
        chk("rr_last", W'(last_g), 1);

        rnd(0); rnd(1);
        op(6, 3, 0, 0);
        op(int'($urandom_range(1, 6)), 0, 0, 0);

        rnd(0); r_valid[0] = 1'b1;
        op(0, 0, 0, 0);

        rnd(1); r_valid[1] = 1'b1;
        op(2, 0, 0, 1);
        rnd(0); rnd(1); r_valid[0] = 1'b1; r_valid[1] = 1'b1;
        op(3, 0, 0, 0);
        chk("grant_after_rst", W'(last_g), 0);
        op(3, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            for (int q = 0; q < 2; q++)
                if (!r_valid[q] && ($urandom % 2) == 1) begin rnd(q); r_valid[q] = 1'b1; end
            if (!r_valid[0] && !r_valid[1]) begin rnd(0); r_valid[0] = 1'b1; end
            op(int'($urandom_range(1, 6)), 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
